obstacle_collision_checker: RTL and testbench

Downstream consumer of the obstacle generator's per-frame obstacle stream. It compares each streamed obstacle against the player's lane, height and duck state at the fixed player depth. At the end of each frame it reports whether a crash occurred and the ground height under the player, which drives the physics and game-over logic.

---
 rtl/obstacle_pkg.sv | 39 +++
 rtl/obstacle_hit_eval.sv | 75 +++++++
 rtl/obstacle_collision_checker.sv | 168 ++++++++++++++++
 tb/tb_obstacle_collision_checker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// -----------------------------------------------------------------------------
// obstacle_pkg
// Definitions shared by the obstacle generator and the collision checker:
// obstacle type codes, the field layout of a streamed obstacle word, world
// geometry constants, and the checker FSM state type.
// -----------------------------------------------------------------------------
package obstacle_pkg;

    typedef enum logic [2:0] {
        OBS_NONE  = 3'd0,
        OBS_LOW   = 3'd1,
        OBS_HIGH  = 3'd2,
        OBS_MID   = 3'd3,
        OBS_TRAIN = 3'd4,
        OBS_RAMP  = 3'd5,
        OBS_CAR   = 3'd6
    } obs_type_e;

    // obs_data = {type[2:0], lane[1:0], depth[10:0]}; depth is the far end.
    localparam int OBS_DATA_W    = 16;
    localparam int OBS_DEPTH_LSB = 0;
    localparam int OBS_DEPTH_W   = 11;
    localparam int OBS_LANE_LSB  = 11;
    localparam int OBS_LANE_W    = 2;
    localparam int OBS_TYPE_LSB  = 13;
    localparam int OBS_TYPE_W    = 3;

    localparam int HALF_BLOCK = 64;
    localparam int TRAIN_LEN  = 128;

    localparam int OFFSET_W = 12;
    localparam int HEIGHT_W = 7;

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_REPORT = 1'b1
    } chk_state_e;

endpackage

// File: rtl/obstacle_hit_eval.sv
// -----------------------------------------------------------------------------
// obstacle_hit_eval
// Combinational per-obstacle rule evaluation. Given an in-lane obstacle's type,
// its signed depth offset from the player and the player snapshot, decides
// whether the player collides with it and how high it can hold the player up.
// Negative offsets must be filtered by the caller.
//
// Ports:
//   type_i      obstacle type code
//   offset_i    far-end depth minus player depth (signed)
//   height_i    player height above track
//   ducking_i   player duck state
//   hit_o       collision with this obstacle
//   support_o   support height this obstacle provides (0 if none)
// -----------------------------------------------------------------------------
module obstacle_hit_eval
    import obstacle_pkg::*;
#(
    parameter int BARRIER_LEN   = 16,
    parameter int TRAIN_LEN_P   = TRAIN_LEN,
    parameter int TRAIN_H       = 64,
    parameter int STEP_TOL      = 8,
    parameter int BARRIER_LOW_H = 24
) (
    input  logic [OBS_TYPE_W-1:0]       type_i,
    input  logic signed [OFFSET_W-1:0]  offset_i,
    input  logic [HEIGHT_W-1:0]         height_i,
    input  logic                        ducking_i,
    output logic                        hit_o,
    output logic [HEIGHT_W-1:0]         support_o
);

    localparam logic signed [OFFSET_W-1:0] BARRIER_LEN_S = OFFSET_W'(BARRIER_LEN);
    localparam logic signed [OFFSET_W-1:0] TRAIN_LEN_S   = OFFSET_W'(TRAIN_LEN_P);
    localparam logic [HEIGHT_W-1:0]        LOW_H_V       = HEIGHT_W'(BARRIER_LOW_H);
    localparam logic [HEIGHT_W-1:0]        ROOF_MIN_V    = HEIGHT_W'(TRAIN_H - STEP_TOL);
    localparam logic [HEIGHT_W-1:0]        TRAIN_H_V     = HEIGHT_W'(TRAIN_H);

    logic in_barrier;
    logic in_train;
    logic below_low;
    logic on_roof;

    assign in_barrier = offset_i < BARRIER_LEN_S;
    assign in_train   = offset_i < TRAIN_LEN_S;
    assign below_low  = height_i < LOW_H_V;
    assign on_roof    = height_i >= ROOF_MIN_V;

    always_comb begin
        hit_o     = 1'b0;
        support_o = '0;
        case (obs_type_e'(type_i))
            OBS_LOW:  hit_o = in_barrier && below_low;
            OBS_HIGH: hit_o = in_barrier && !ducking_i;
            OBS_MID:  hit_o = in_barrier && !ducking_i && below_low;
            OBS_TRAIN: begin
                if (in_train) begin
                    if (on_roof) begin
                        support_o = TRAIN_H_V;
                    end else begin
                        hit_o = 1'b1;
                    end
                end
            end
            OBS_RAMP: begin
                // Slope rises linearly: half the remaining ramp length.
                if (in_train) begin
                    support_o = HEIGHT_W'($unsigned(TRAIN_LEN_S - offset_i) >> 1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/obstacle_collision_checker.sv
// -----------------------------------------------------------------------------
// obstacle_collision_checker
// Consumes the per-frame obstacle stream, checks each obstacle against the
// player at the fixed player depth, and once per frame reports whether a
// crash occurred plus the highest support under the player.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   obs_valid_i         obstacle strobe (obs_data_i valid)
//   obs_first_row_i     near-row flag from generator (not used)
//   obs_data_i          {type, lane, depth}
//   obs_done_i          end-of-frame strobe
//   player_lane_i       player lane 0..2
//   player_height_i     player height above track
//   player_ducking_i    player duck state
//   result_valid_o      one-cycle pulse per frame, 3 cycles after done
//   crash_o             frame had a collision (held)
//   crash_type_o        type of first colliding obstacle, 0 if none (held)
//   ground_height_o     max support under player (held)
//
// state     | meaning
// ST_ACCUM  | collecting obstacle contributions for the current frame
// ST_REPORT | result_valid_o high; outputs hold the just-finished frame
// -----------------------------------------------------------------------------
module obstacle_collision_checker
    import obstacle_pkg::*;
#(
    parameter int PLAYER_DEPTH  = HALF_BLOCK,
    parameter int BARRIER_LEN   = 16,
    parameter int TRAIN_LEN_P   = TRAIN_LEN,
    parameter int TRAIN_H       = 64,
    parameter int STEP_TOL      = 8,
    parameter int BARRIER_LOW_H = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    obs_valid_i,
    input  logic                    obs_first_row_i,
    input  logic [OBS_DATA_W-1:0]   obs_data_i,
    input  logic                    obs_done_i,
    input  logic [1:0]              player_lane_i,
    input  logic [HEIGHT_W-1:0]     player_height_i,
    input  logic                    player_ducking_i,
    output logic                    result_valid_o,
    output logic                    crash_o,
    output logic [OBS_TYPE_W-1:0]   crash_type_o,
    output logic [HEIGHT_W-1:0]     ground_height_o
);

    logic unused_first_row;
    assign unused_first_row = obs_first_row_i;

    // Stage 1: offset, lane match and player snapshot.
    logic                        s1_valid_q;
    logic                        s1_done_q;
    logic [OBS_TYPE_W-1:0]       s1_type_q;
    logic signed [OFFSET_W-1:0]  s1_offset_q;
    logic                        s1_in_lane_q;
    logic [HEIGHT_W-1:0]         s1_height_q;
    logic                        s1_duck_q;
    logic signed [OFFSET_W-1:0]  offset_d;

    assign offset_d = $signed({1'b0, obs_data_i[OBS_DEPTH_LSB +: OBS_DEPTH_W]}
                              - OFFSET_W'(PLAYER_DEPTH));

    // Stage 2: accumulators and matching done delay.
    logic                    s2_done_q;
    logic                    acc_hit_q,    acc_hit_d;
    logic [OBS_TYPE_W-1:0]   acc_type_q,   acc_type_d;
    logic [HEIGHT_W-1:0]     acc_ground_q, acc_ground_d;
    chk_state_e              state_q;

    logic                    eval_hit;
    logic [HEIGHT_W-1:0]     eval_support;

    obstacle_hit_eval #(
        .BARRIER_LEN   (BARRIER_LEN),
        .TRAIN_LEN_P   (TRAIN_LEN_P),
        .TRAIN_H       (TRAIN_H),
        .STEP_TOL      (STEP_TOL),
        .BARRIER_LOW_H (BARRIER_LOW_H)
    ) u_hit_eval (
        .type_i    (s1_type_q),
        .offset_i  (s1_offset_q),
        .height_i  (s1_height_q),
        .ducking_i (s1_duck_q),
        .hit_o     (eval_hit),
        .support_o (eval_support)
    );

    logic                    contrib;
    logic                    eff_hit;
    logic [HEIGHT_W-1:0]     eff_support;
    logic                    base_hit;
    logic [OBS_TYPE_W-1:0]   base_type;
    logic [HEIGHT_W-1:0]     base_ground;

    // The edge that loads the outputs also restarts the accumulators from the
    // obstacle currently leaving stage 1, so an obstacle that arrived right
    // after done lands in the next frame instead of being cleared away.
    always_comb begin
        contrib     = s1_valid_q && s1_in_lane_q && !s1_offset_q[OFFSET_W-1];
        eff_hit     = contrib && eval_hit;
        eff_support = contrib ? eval_support : '0;
        base_hit    = s2_done_q ? 1'b0 : acc_hit_q;
        base_type   = s2_done_q ? '0   : acc_type_q;
        base_ground = s2_done_q ? '0   : acc_ground_q;

        acc_hit_d    = base_hit | eff_hit;
        acc_type_d   = (eff_hit && !base_hit) ? s1_type_q : base_type;
        acc_ground_d = (eff_support > base_ground) ? eff_support : base_ground;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q      <= 1'b0;
            s1_done_q       <= 1'b0;
            s1_type_q       <= '0;
            s1_offset_q     <= '0;
            s1_in_lane_q    <= 1'b0;
            s1_height_q     <= '0;
            s1_duck_q       <= 1'b0;
            s2_done_q       <= 1'b0;
            acc_hit_q       <= 1'b0;
            acc_type_q      <= '0;
            acc_ground_q    <= '0;
            state_q         <= ST_ACCUM;
            result_valid_o  <= 1'b0;
            crash_o         <= 1'b0;
            crash_type_o    <= '0;
            ground_height_o <= '0;
        end else begin
            s1_valid_q   <= obs_valid_i;
            s1_done_q    <= obs_done_i;
            s1_type_q    <= obs_data_i[OBS_TYPE_LSB +: OBS_TYPE_W];
            s1_offset_q  <= offset_d;
            s1_in_lane_q <= obs_data_i[OBS_LANE_LSB +: OBS_LANE_W] == player_lane_i;
            s1_height_q  <= player_height_i;
            s1_duck_q    <= player_ducking_i;
            s2_done_q    <= s1_done_q;

            acc_hit_q    <= acc_hit_d;
            acc_type_q   <= acc_type_d;
            acc_ground_q <= acc_ground_d;

            // Back-to-back frames may re-enter REPORT directly.
            case (state_q)
                ST_ACCUM, ST_REPORT: begin
                    if (s2_done_q) begin
                        state_q         <= ST_REPORT;
                        result_valid_o  <= 1'b1;
                        crash_o         <= acc_hit_q;
                        crash_type_o    <= acc_type_q;
                        ground_height_o <= acc_ground_q;
                    end else begin
                        state_q        <= ST_ACCUM;
                        result_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= ST_ACCUM;
                    result_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_collision_checker.sv
module tb_obstacle_collision_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        obs_valid_i = 1'b0;
    logic        obs_first_row_i = 1'b0;
    logic [15:0] obs_data_i = '0;
    logic        obs_done_i = 1'b0;
    logic [1:0]  player_lane_i = '0;
    logic [6:0]  player_height_i = '0;
    logic        player_ducking_i = 1'b0;
    logic        result_valid_o;
    logic        crash_o;
    logic [2:0]  crash_type_o;
    logic [6:0]  ground_height_o;

    obstacle_collision_checker dut (
        .clk              (clk),
        .rst              (rst),
        .obs_valid_i      (obs_valid_i),
        .obs_first_row_i  (obs_first_row_i),
        .obs_data_i       (obs_data_i),
        .obs_done_i       (obs_done_i),
        .player_lane_i    (player_lane_i),
        .player_height_i  (player_height_i),
        .player_ducking_i (player_ducking_i),
        .result_valid_o   (result_valid_o),
        .crash_o          (crash_o),
        .crash_type_o     (crash_type_o),
        .ground_height_o  (ground_height_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check(input string name, input int got, input int exp);
        n_asserts++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference rules, written directly from the game geometry in plain ints.
    function automatic void ref_obstacle(input int typ, input int lane, input int depth,
                                         input int pl, input int ph, input bit pd,
                                         output bit hit, output int sup);
        int off;
        hit = 0;
        sup = 0;
        off = depth - 64;
        if (lane != pl || off < 0) return;
        if (typ == 1 && off < 16 && ph < 24) hit = 1;
        if (typ == 2 && off < 16 && !pd) hit = 1;
        if (typ == 3 && off < 16 && !pd && ph < 24) hit = 1;
        if (typ == 4 && off < 128) begin
            if (ph >= 64 - 8) sup = 64;
            else hit = 1;
        end
        if (typ == 5 && off < 128) sup = (128 - off) / 2;
    endfunction

    typedef struct {
        int due;
        bit hit;
        int typ;
        int ground;
    } res_t;

    res_t q[$];
    bit   m_hit = 0;
    int   m_type = 0;
    int   m_ground = 0;
    int   zero_at = -1;
    bit   checking = 0;
    bit   h_hit = 0;
    int   h_type = 0;
    int   h_ground = 0;

    task automatic drive(input bit v, input int typ, input int lane, input int depth,
                         input bit done, input int pl, input int ph, input bit pd,
                         input bit r);
        bit hit;
        int sup;
        obs_valid_i      = v;
        obs_data_i       = {3'(typ), 2'(lane), 11'(depth)};
        obs_done_i       = done;
        player_lane_i    = 2'(pl);
        player_height_i  = 7'(ph);
        player_ducking_i = pd;
        obs_first_row_i  = 1'($urandom_range(0, 1));
        rst              = r;
        if (r) begin
            m_hit = 0; m_type = 0; m_ground = 0;
            while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
            zero_at = cyc + 1;
        end else begin
            if (v) begin
                ref_obstacle(typ, lane, depth, pl, ph, pd, hit, sup);
                if (hit && !m_hit) m_type = typ;
                m_hit = m_hit | hit;
                if (sup > m_ground) m_ground = sup;
            end
            if (done) begin
                q.push_back('{due: cyc + 3, hit: m_hit, typ: m_type, ground: m_ground});
                m_hit = 0; m_type = 0; m_ground = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, $urandom_range(0, 2), $urandom_range(0, 127),
              1'($urandom_range(0, 1)), 0);
    endtask

    task automatic obs(input int typ, input int lane, input int depth,
                       input int pl, input int ph, input bit pd);
        drive(1, typ, lane, depth, 0, pl, ph, pd, 0);
    endtask

    task automatic done_and_wait();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        repeat (3) idle();
    endtask

    always @(negedge clk) begin
        if (checking) begin
            bit exp_v;
            if (zero_at == cyc) begin
                h_hit = 0; h_type = 0; h_ground = 0;
            end
            exp_v = (q.size() > 0 && q[0].due == cyc);
            if (exp_v) begin
                h_hit    = q[0].hit;
                h_type   = q[0].typ;
                h_ground = q[0].ground;
                void'(q.pop_front());
            end
            check("result_valid", int'(result_valid_o), int'(exp_v));
            check("crash", int'(crash_o), int'(h_hit));
            check("crash_type", int'(crash_type_o), h_type);
            check("ground_height", int'(ground_height_o), h_ground);
        end
    end

    int hsel[8];
    int dsel[8];

    initial begin
        bit ph;
        int ps;
        hsel = '{0, 23, 24, 55, 56, 60, 127, 1};
        dsel = '{63, 64, 79, 80, 191, 192, 68, 100};

        // Pin the reference rules with hand-computed values.
        ref_obstacle(4, 1, 100, 1, 0, 0, ph, ps);
        check("pin_train_low_hit", int'(ph), 1);
        ref_obstacle(4, 1, 100, 1, 60, 0, ph, ps);
        check("pin_train_roof_sup", ps, 64);
        ref_obstacle(5, 0, 128, 0, 0, 0, ph, ps);
        check("pin_ramp_sup", ps, 32);
        ref_obstacle(2, 2, 72, 2, 0, 1, ph, ps);
        check("pin_duck_clear", int'(ph), 0);
        ref_obstacle(1, 0, 80, 0, 0, 0, ph, ps);
        check("pin_barrier_edge", int'(ph), 0);
        ref_obstacle(4, 1, 192, 1, 0, 0, ph, ps);
        check("pin_train_edge", int'(ph) + ps, 0);

        repeat (3) @(posedge clk);
        #1;
        checking = 1;
        check("reset_crash", int'(crash_o), 0);
        check("reset_valid", int'(result_valid_o), 0);

        // 1: train, player on ground
        obs(4, 1, 100, 1, 0, 0);
        done_and_wait();
        check("t1_crash", int'(crash_o), 1);
        check("t1_type", int'(crash_type_o), 4);
        check("t1_ground", int'(ground_height_o), 0);
        // 2: same train, player on roof height
        obs(4, 1, 100, 1, 60, 0);
        done_and_wait();
        check("t2_crash", int'(crash_o), 0);
        check("t2_ground", int'(ground_height_o), 64);
        // 3: ramp mid-slope
        obs(5, 0, 128, 0, 0, 0);
        done_and_wait();
        check("t3_ground", int'(ground_height_o), 32);
        // 4: duck barrier both ways
        obs(2, 2, 72, 2, 0, 1);
        done_and_wait();
        check("t4a_crash", int'(crash_o), 0);
        obs(2, 2, 72, 2, 0, 0);
        done_and_wait();
        check("t4b_crash", int'(crash_o), 1);
        check("t4b_type", int'(crash_type_o), 2);
        // 5: other lane, train far edge, barrier behind player
        obs(4, 0, 100, 1, 0, 0);
        obs(4, 1, 192, 1, 0, 0);
        obs(1, 1, 40, 1, 0, 0);
        done_and_wait();
        check("t5_crash", int'(crash_o), 0);
        check("t5_ground", int'(ground_height_o), 0);
        // 6: first-hit type kept, then reset mid-frame
        obs(1, 0, 68, 0, 0, 0);
        obs(4, 0, 100, 0, 0, 0);
        done_and_wait();
        check("t6_type", int'(crash_type_o), 1);
        obs(4, 0, 100, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (4) idle();
        check("t6_rst_crash", int'(crash_o), 0);
        check("t6_rst_type", int'(crash_type_o), 0);
        // empty frame
        done_and_wait();
        check("empty_crash", int'(crash_o), 0);

        // Randomized frames
        for (int f = 0; f < 250; f++) begin
            int nobs;
            bit merged;
            nobs = $urandom_range(0, 5);
            merged = 0;
            for (int k = 0; k < nobs; k++) begin
                int typ, lane, depth, pl, ht;
                bit last_done;
                repeat ($urandom_range(0, 2)) idle();
                typ = $urandom_range(0, 7);
                pl  = $urandom_range(0, 2);
                lane = ($urandom_range(0, 1) == 0) ? pl : $urandom_range(0, 3);
                case ($urandom_range(0, 3))
                    0: depth = $urandom_range(0, 2047);
                    1: depth = $urandom_range(40, 100);
                    2: depth = $urandom_range(60, 200);
                    default: depth = dsel[$urandom_range(0, 7)];
                endcase
                ht = hsel[$urandom_range(0, 7)];
                if (ht == 1) ht = $urandom_range(0, 127);
                last_done = (k == nobs - 1) && ($urandom_range(0, 3) == 0);
                merged = last_done;
                drive(1, typ, lane, depth, last_done, pl, ht, 1'($urandom_range(0, 1)), 0);
            end
            if ($urandom_range(0, 19) == 0) begin
                drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
            end else if (!merged) begin
                drive(0, 0, 0, 0, 1, $urandom_range(0, 2), 0, 0, 0);
            end
            repeat ($urandom_range(0, 3)) idle();
        end

        repeat (6) idle();
        check("queue_drained", q.size(), 0);
        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
